term_rx_port: RTL

//  Terminal-side receiver for the mesh router's output interface: the read end of the

---
 rtl/term_rx_port.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/term_rx_port.sv
// term_rx_port: terminal-side receiver for the mesh router output interface.
// Pops pending packets from the router with a one-cycle pop strobe, buffers
// them in a circular FIFO with first-word fall-through, decodes the head
// packet's header fields and counts total and misrouted arrivals.
module term_rx_port #(
  parameter int unsigned PCKG_SZ = 40,
  parameter int unsigned DEPTH   = 8,
  parameter logic [3:0]  MY_ROW  = 4'd0,
  parameter logic [3:0]  MY_COL  = 4'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pndng_i,
  input  logic [PCKG_SZ-1:0]         data_out_i,
  output logic                       pop_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [PCKG_SZ-1:0]         rd_data_o,
  output logic [3:0]                 rd_row_o,
  output logic [3:0]                 rd_col_o,
  output logic                       rd_mode_o,
  output logic [PCKG_SZ-18:0]        rd_payload_o,
  output logic                       rd_misroute_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [15:0]                pkt_cnt_o,
  output logic [15:0]                misroute_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PCKG_SZ-1:0]  mem_q [DEPTH];
  logic [PCKG_SZ-1:0]  mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         mis_cnt_q, mis_cnt_d;

  logic                wr_en;
  logic                rd_en;
  logic                space;
  logic                wr_misroute;

  // Handshake qualifiers: write happens on the POP cycle, read on valid&ready.
  // A full FIFO still has space when the head is consumed this same cycle;
  // the write lands one cycle later, so it can never overflow.
  always_comb begin
    wr_en       = (state_q == ST_POP);
    rd_en       = (count_q != '0) && rd_ready_i;
    space       = (count_q != CW'(DEPTH)) || rd_en;
    wr_misroute = (data_out_i[PCKG_SZ-9 -: 4] != MY_ROW) ||
                  (data_out_i[PCKG_SZ-13 -: 4] != MY_COL);
  end

  // Rx FSM next state: IDLE -> POP -> WAIT -> IDLE; WAIT gives the router a
  // cycle to refresh pndng_i/data_out_i after each pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pndng_i && space) state_d = ST_POP;
      ST_POP:  state_d = ST_WAIT;
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage, pointers and occupancy next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = data_out_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Saturating arrival counters, bumped on each FIFO write.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (wr_en) begin
      if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (wr_misroute && (mis_cnt_q != 16'hFFFF)) mis_cnt_d = mis_cnt_q + 16'd1;
    end
  end

  // State register; reset drops any packet popped in the reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
      mis_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_cnt_q <= pkt_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      mem_q     <= mem_d;
    end
  end

  // Outputs: pop from state only; head fields decoded from the FIFO head.
  always_comb begin
    pop_o          = (state_q == ST_POP);
    rd_valid_o     = (count_q != '0);
    rd_data_o      = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    rd_row_o       = rd_data_o[PCKG_SZ-9 -: 4];
    rd_col_o       = rd_data_o[PCKG_SZ-13 -: 4];
    rd_mode_o      = rd_data_o[PCKG_SZ-17];
    rd_payload_o   = rd_data_o[PCKG_SZ-18:0];
    rd_misroute_o  = (rd_row_o != MY_ROW) || (rd_col_o != MY_COL);
    count_o        = count_q;
    pkt_cnt_o      = pkt_cnt_q;
    misroute_cnt_o = mis_cnt_q;
  end

endmodule
